// File: rtl/pp_red_pkg.sv
// pp_red_pkg: shared defaults and FSM encoding for the pp_ red-pixel frame blocks
// Contents: default frame geometry, default detection threshold, tracker state enum.
package pp_red_pkg;
    localparam int H_ACTIVE_DEF  = 640;
    localparam int V_ACTIVE_DEF  = 480;
    localparam int MIN_COUNT_DEF = 64;
    typedef enum logic {ST_IDLE, ST_ACCUM} state_t;
endpackage

// File: rtl/pp_pixel_coord_counter.sv
// pp_pixel_coord_counter: raster x/y counter giving the coordinate of the pixel presented now
// Ports: i_clk, i_rst (sync, active-high), i_en (pixel consumed), i_seed (this pixel is (0,0)),
//        o_x/o_y (coordinate of the presented pixel), o_last (presented pixel ends the frame).
module pp_pixel_coord_counter
    import pp_red_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    localparam int X_W = $clog2(H_ACTIVE),
    localparam int Y_W = $clog2(V_ACTIVE)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_en,
    input  logic           i_seed,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_last
);
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic           x_end, y_end;
    // registers hold the coordinate of the next expected pixel; a seed overrides it with (0,0)
    always_comb begin
        o_x    = i_seed ? '0 : x_q;
        o_y    = i_seed ? '0 : y_q;
        x_end  = o_x == X_W'(H_ACTIVE - 1);
        y_end  = o_y == Y_W'(V_ACTIVE - 1);
        o_last = x_end && y_end;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (i_en) begin
            x_q <= x_end ? '0 : o_x + X_W'(1);
            y_q <= x_end ? (y_end ? '0 : o_y + Y_W'(1)) : o_y;
        end
    end
endmodule

// File: rtl/pp_red_bbox_tracker.sv
// pp_red_bbox_tracker: per-frame red-pixel count and bounding box with an end-of-frame report strobe
// Ports: i_clk, i_rst (sync, active-high), i_valid/i_pixel_is_red/i_sof (detector stream),
//        o_bbox_valid (report strobe), o_x_min/o_x_max/o_y_min/o_y_max, o_red_count, o_detected,
//        o_sync_err (strobe: frame restarted before its last pixel).
module pp_red_bbox_tracker
    import pp_red_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int MIN_COUNT = MIN_COUNT_DEF,
    localparam int X_W = $clog2(H_ACTIVE),
    localparam int Y_W = $clog2(V_ACTIVE),
    localparam int C_W = $clog2(H_ACTIVE * V_ACTIVE + 1)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_valid,
    input  logic           i_pixel_is_red,
    input  logic           i_sof,
    output logic           o_bbox_valid,
    output logic [X_W-1:0] o_x_min,
    output logic [X_W-1:0] o_x_max,
    output logic [Y_W-1:0] o_y_min,
    output logic [Y_W-1:0] o_y_max,
    output logic [C_W-1:0] o_red_count,
    output logic           o_detected,
    output logic           o_sync_err
);
    state_t         state_q, state_d;
    logic           en, seed, last, report, sync_err, red;
    logic [X_W-1:0] cx, x_min_q, x_max_q, bx_min, bx_max, x_min_n, x_max_n;
    logic [Y_W-1:0] cy, y_min_q, y_max_q, by_min, by_max, y_min_n, y_max_n;
    logic [C_W-1:0] cnt_q, b_cnt, cnt_n;

    pp_pixel_coord_counter #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_coord (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (en),
        .i_seed (seed),
        .o_x    (cx),
        .o_y    (cy),
        .o_last (last)
    );

    always_comb begin
        seed     = i_valid && i_sof;
        en       = i_valid && (i_sof || state_q == ST_ACCUM);
        sync_err = seed && state_q == ST_ACCUM;
        report   = en && !seed && last;
        state_d  = seed ? ST_ACCUM : (report ? ST_IDLE : state_q);
    end

    // a seed starts from an "empty" box so the common red-pixel update below also seeds it
    always_comb begin
        red     = i_pixel_is_red;
        bx_min  = seed ? X_W'(H_ACTIVE - 1) : x_min_q;
        bx_max  = seed ? '0 : x_max_q;
        by_min  = seed ? Y_W'(V_ACTIVE - 1) : y_min_q;
        by_max  = seed ? '0 : y_max_q;
        b_cnt   = seed ? '0 : cnt_q;
        x_min_n = (red && cx < bx_min) ? cx : bx_min;
        x_max_n = (red && cx > bx_max) ? cx : bx_max;
        y_min_n = (red && cy < by_min) ? cy : by_min;
        y_max_n = (red && cy > by_max) ? cy : by_max;
        cnt_n   = b_cnt + C_W'(red);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            x_min_q      <= '0;
            x_max_q      <= '0;
            y_min_q      <= '0;
            y_max_q      <= '0;
            cnt_q        <= '0;
            o_bbox_valid <= 1'b0;
            o_sync_err   <= 1'b0;
            o_x_min      <= '0;
            o_x_max      <= '0;
            o_y_min      <= '0;
            o_y_max      <= '0;
            o_red_count  <= '0;
            o_detected   <= 1'b0;
        end else begin
            state_q      <= state_d;
            o_bbox_valid <= report;
            o_sync_err   <= sync_err;
            if (en) begin
                x_min_q <= x_min_n;
                x_max_q <= x_max_n;
                y_min_q <= y_min_n;
                y_max_q <= y_max_n;
                cnt_q   <= cnt_n;
            end
            // an empty frame reports a zero box rather than the inverted seed values
            if (report) begin
                o_x_min     <= cnt_n == '0 ? '0 : x_min_n;
                o_x_max     <= cnt_n == '0 ? '0 : x_max_n;
                o_y_min     <= cnt_n == '0 ? '0 : y_min_n;
                o_y_max     <= cnt_n == '0 ? '0 : y_max_n;
                o_red_count <= cnt_n;
                o_detected  <= cnt_n >= C_W'(MIN_COUNT);
            end
        end
    end
endmodule

// File: doc/pp_red_bbox_tracker.md
# pp_red_bbox_tracker

Frame-level controller that sequences the red-pixel detector output across a video frame. It tracks raster coordinates of every valid detector result and accumulates the red-pixel count and bounding box (x/y min/max). At end of frame it publishes one report pulse. It sits directly downstream of the per-pixel red classifier in the pixel-processing (pp_) chain and feeds overlay/target logic.

## Interface
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- MIN_COUNT, 64, minimum red pixels for o_detected
- X_W / Y_W / C_W (localparams): $clog2(H_ACTIVE), $clog2(V_ACTIVE), $clog2(H_ACTIVE*V_ACTIVE+1)

Ports:
- i_clk  in  1  sole clock
- i_rst  in  1  reset; synchronous, active-high
- i_valid  in  1  detector result valid (one pixel per asserted cycle)
- i_pixel_is_red  in  1  classification for this pixel; qualified by i_valid
- i_sof  in  1  first pixel of frame; qualified by i_valid, aligned with detector output
- o_bbox_valid  out  1  one-cycle report strobe
- o_x_min, o_x_max  out  X_W  bounding box columns
- o_y_min, o_y_max  out  Y_W  bounding box rows
- o_red_count  out  C_W  red pixels in reported frame
- o_detected  out  1  o_red_count >= MIN_COUNT
- o_sync_err  out  1  one-cycle strobe: frame restarted early

## Operation
- States: IDLE, ACCUM.
- IDLE: i_valid & !i_sof ignored. i_valid & i_sof: pixel taken as (0,0), accumulators seeded from it, go ACCUM.
- Seeding: if red → min=max=coord, count=1; else x_min=H_ACTIVE-1, y_min=V_ACTIVE-1, max=0, count=0.
- ACCUM, i_valid & !i_sof: x+1; at x==H_ACTIVE-1 wrap to 0, y+1. Red pixel: count+1, min/max updated against current coord.
- ACCUM, i_valid & i_sof: o_sync_err pulse next cycle; partial frame discarded, no report; re-seed with this pixel as (0,0); stay ACCUM.
- Last pixel (x==H_ACTIVE-1, y==V_ACTIVE-1, i_valid, !i_sof): result including this pixel is latched into outputs on the same edge; go IDLE. Report strobe as per Timing.
- Report fields: o_detected = count>=MIN_COUNT. If count==0, all bbox outputs are 0; otherwise true min/max regardless of o_detected.
- Outputs hold last report until next report or reset.
- i_valid low: no state/coordinate change (gaps allowed anywhere).
- Count never exceeds H_ACTIVE*V_ACTIVE; no saturation needed.

## Timing
- Reset: state IDLE; x, y, accumulators 0; o_bbox_valid 0, o_sync_err 0, all bbox outputs 0, o_red_count 0, o_detected 0.
- Reset mid-frame: frame abandoned, no report, no sync_err.
- Latency: last pixel accepted at edge N → o_bbox_valid high for the cycle after edge N, exactly one cycle; report fields valid in same cycle.
- Back-to-back: i_sof accepted on the cycle immediately after last pixel (IDLE accepts at once); no pixel dropped.
- o_sync_err: high exactly one cycle after edge accepting the early i_sof.
- No backpressure: every i_valid pixel is consumed the cycle it appears.

## Structure
- Shared package/header pp_red_pkg: default H_ACTIVE/V_ACTIVE, state encodings, width helper constants.
- One sub-module: pp_pixel_coord_counter (x/y raster counter with clear/seed, enable, wrap, last-pixel flag), reused by later pp_ blocks.
- Accumulator, FSM, output registers in the top.

## Test plan
Sim parameters H_ACTIVE=8, V_ACTIVE=4, MIN_COUNT=4.
- Reset: hold i_rst 3 cycles with random inputs → all outputs 0, no strobes.
- Red block x=2..5, y=1..2, contiguous frame → one pulse one cycle after pixel 31: x 2/5, y 1/2, count 8, detected 1.
- No red pixels → count 0, detected 0, all bbox 0; single red at (7,3) → bbox 7/7/3/3, count 1, detected 0.
- i_sof re-asserted at pixel 13 → o_sync_err pulse, no report; report after 32 further pixels reflects only the new frame.
- Random i_valid gaps plus i_valid without i_sof while IDLE → identical report to the gap-free run; stray pixels ignored.
- Reset at pixel 20, then two back-to-back frames (second i_sof on cycle after last pixel) → exactly two correct reports, none for the aborted frame.
